// File: rtl/vjtag_pkg.sv
// vjtag_pkg: shared state encoding and default widths for the virtual-JTAG scan driver
package vjtag_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IR_W   = 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    UPDATE,
    DONE
  } state_t;

endpackage

// File: rtl/vjtag_tck_gen.sv
// vjtag_tck_gen: registered tck with CLK_DIV-cycle half periods and edge-anticipating pulses
module vjtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tck,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic period_done
);

  logic [7:0] cnt;
  logic       term;

  assign term        = enable && cnt == 8'(CLK_DIV - 1);
  assign rise_pulse  = term && !tck;
  assign fall_pulse  = term && tck;
  assign period_done = fall_pulse;

  // half-period counter; tck parks low with the counter cleared whenever disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!enable) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (term) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/vjtag_scan_driver.sv
// vjtag_scan_driver: virtual-JTAG DR scan initiator, one command in and one captured word out
module vjtag_scan_driver
  import vjtag_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int IR_W    = DEF_IR_W,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_cmd_valid,
  output logic              io_cmd_ready,
  input  logic [IR_W-1:0]   io_cmd_ir,
  input  logic [DATA_W-1:0] io_cmd_data,
  output logic              io_rsp_valid,
  input  logic              io_rsp_ready,
  output logic [DATA_W-1:0] io_rsp_data,
  output logic              io_tck,
  output logic              io_tdi,
  input  logic              io_tdo,
  output logic [IR_W-1:0]   io_ir_in,
  output logic              io_v_sdr,
  output logic              io_udr
);

  localparam int BW = $clog2(DATA_W + 1);

  state_t            state;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] data_sh;
  logic [DATA_W-1:0] data_nxt;
  logic              enable;
  logic              last;
  logic              rise_pulse;
  logic              fall_pulse;
  logic              period_done;

  assign enable      = state inside {SETUP, SHIFT, UPDATE};
  assign last        = bit_cnt == BW'(DATA_W - 1);
  assign data_nxt    = data_sh >> 1;

  vjtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tck        (io_tck),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .period_done(period_done)
  );

  // scan sequencer; every output is registered so tdi/sdr/udr move only on tck edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      io_cmd_ready <= 1'b1;
      io_rsp_valid <= 1'b0;
      io_rsp_data  <= '0;
      io_tdi       <= 1'b0;
      io_ir_in     <= '0;
      io_v_sdr     <= 1'b0;
      io_udr       <= 1'b0;
      data_sh      <= '0;
      bit_cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (io_cmd_valid && io_cmd_ready) begin
          state        <= SETUP;
          io_cmd_ready <= 1'b0;
          io_ir_in     <= io_cmd_ir;
          data_sh      <= io_cmd_data;
          io_tdi       <= io_cmd_data[0];
          bit_cnt      <= '0;
        end
        SETUP: if (period_done) begin
          state    <= SHIFT;
          io_v_sdr <= 1'b1;
        end
        SHIFT: begin
          if (rise_pulse) io_rsp_data <= {io_tdo, io_rsp_data[DATA_W-1:1]};
          if (fall_pulse && !last) begin
            bit_cnt <= bit_cnt + 1'b1;
            data_sh <= data_nxt;
            io_tdi  <= data_nxt[0];
          end
          if (period_done && last) begin
            state    <= UPDATE;
            io_v_sdr <= 1'b0;
            io_udr   <= 1'b1;
            io_tdi   <= 1'b0;
          end
        end
        UPDATE: if (period_done) begin
          state        <= DONE;
          io_udr       <= 1'b0;
          io_ir_in     <= '0;
          io_rsp_valid <= 1'b1;
        end
        DONE: if (io_rsp_ready) begin
          state        <= IDLE;
          io_rsp_valid <= 1'b0;
          io_cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vjtag_scan_driver.sv
// tb_vjtag_scan_driver: directed and randomized scans against a bit-level loopback model
module tb_vjtag_scan_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       io_cmd_valid = 1'b0;
  logic       io_cmd_ready;
  logic [0:0] io_cmd_ir = '0;
  logic [7:0] io_cmd_data = '0;
  logic       io_rsp_valid;
  logic       io_rsp_ready = 1'b0;
  logic [7:0] io_rsp_data;
  logic       io_tck;
  logic       io_tdi;
  logic       io_tdo;
  logic [0:0] io_ir_in;
  logic       io_v_sdr;
  logic       io_udr;

  logic [1:0] tdo_mode = 2'd0;
  int         vectors = 0;
  int         miscompares = 0;
  logic       tdi_q[$];
  int         udr_cnt = 0;
  logic       overlap = 1'b0;
  logic       tdi_or = 1'b0;
  logic [14:0] outs;

  assign io_tdo = tdo_mode == 2'd0 ? io_tdi : tdo_mode == 2'd1 ? 1'b1 : ~io_tdi;
  assign outs = {io_cmd_ready, io_rsp_valid, io_rsp_data, io_tck, io_tdi, io_ir_in, io_v_sdr, io_udr};

  vjtag_scan_driver #(.DATA_W(8), .IR_W(1), .CLK_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .io_cmd_valid(io_cmd_valid),
    .io_cmd_ready(io_cmd_ready),
    .io_cmd_ir   (io_cmd_ir),
    .io_cmd_data (io_cmd_data),
    .io_rsp_valid(io_rsp_valid),
    .io_rsp_ready(io_rsp_ready),
    .io_rsp_data (io_rsp_data),
    .io_tck      (io_tck),
    .io_tdi      (io_tdi),
    .io_tdo      (io_tdo),
    .io_ir_in    (io_ir_in),
    .io_v_sdr    (io_v_sdr),
    .io_udr      (io_udr)
  );

  always #5 clk = ~clk;

  // tdi as the target sees it on each tck rise inside shift-DR
  always @(posedge io_tck) if (io_v_sdr) tdi_q.push_back(io_tdi);

  // per-cycle observations of udr width, sdr/udr exclusivity and any tdi activity
  always @(negedge clk) begin
    if (io_udr) udr_cnt++;
    if (io_udr && io_v_sdr) overlap = 1'b1;
    if (io_tdi) tdi_or = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // target response: tdo bit i is produced while data bit i is on tdi
  function automatic logic [7:0] model(input logic [7:0] d, input logic [1:0] m);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = m == 2'd0 ? d[i] : m == 2'd1 ? 1'b1 : ~d[i];
    return r;
  endfunction

  task automatic scan(input logic ir, input logic [7:0] d, input logic [1:0] m, input int hold);
    logic [7:0] exp;
    logic [7:0] w;
    logic       bad;
    int         n;
    exp = model(d, m);
    @(negedge clk);
    tdo_mode = m;
    chk("cmd_ready_idle", io_cmd_ready, 1);
    tdi_q.delete();
    udr_cnt = 0;
    overlap = 1'b0;
    tdi_or = 1'b0;
    io_cmd_valid = 1'b1;
    io_cmd_ir = ir;
    io_cmd_data = d;
    @(posedge clk);
    @(negedge clk);
    io_cmd_valid = 1'b0;
    chk("ir_in_setup", io_ir_in, ir);
    chk("tdi_setup", io_tdi, d[0]);
    chk("cmd_ready_busy", io_cmd_ready, 0);
    n = 0;
    while (!io_rsp_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 80);
    chk("rsp_data", io_rsp_data, exp);
    w = '0;
    for (int i = 0; i < tdi_q.size() && i < 8; i++) w[i] = tdi_q[i];
    chk("tdi_bits", tdi_q.size(), 8);
    chk("tdi_word", w, d);
    chk("tdi_any", tdi_or, |d);
    chk("udr_cycles", udr_cnt, 8);
    chk("sdr_udr_overlap", overlap, 0);
    chk("done_idle_lines", {io_tck, io_ir_in, io_v_sdr, io_udr}, 0);
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      io_cmd_valid = i == 5;
      if (io_rsp_valid !== 1'b1 || io_rsp_data !== exp || io_cmd_ready !== 1'b0) bad = 1'b1;
    end
    if (hold > 0) chk("hold_stable", bad, 0);
    @(negedge clk);
    io_cmd_valid = 1'b0;
    io_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rsp_released", {io_rsp_valid, io_cmd_ready}, 2'b01);
    @(negedge clk);
    io_rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_stays", io_cmd_ready, 1);
  endtask

  initial begin
    logic       any_rsp;
    logic [7:0] d;
    int         n;
    #1 reset = 1'b1;
    #1 chk("reset_outs", outs, 15'h4000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    scan(1'b1, 8'hA5, 2'd0, 0);
    scan(1'b0, 8'h00, 2'd1, 0);
    scan(1'b1, 8'($urandom), 2'd2, 20);
    for (int k = 0; k < 4; k++) scan(1'($urandom), 8'($urandom), 2'($urandom_range(0, 2)), 0);

    @(negedge clk);
    tdo_mode = 2'd0;
    io_cmd_valid = 1'b1;
    io_cmd_data = 8'h3C;
    io_rsp_ready = 1'b1;
    n = 0;
    while (!io_rsp_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_first", io_rsp_data, 8'h3C);
    io_cmd_data = 8'hC3;
    @(posedge clk);
    #1;
    chk("b2b_gap", {io_rsp_valid, io_cmd_ready}, 2'b01);
    @(posedge clk);
    #1;
    chk("b2b_accept", io_cmd_ready, 0);
    n = 2;
    while (!io_rsp_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_spacing", n, 82);
    chk("b2b_second", io_rsp_data, 8'hC3);
    @(negedge clk);
    io_cmd_valid = 1'b0;
    @(negedge clk);
    io_rsp_ready = 1'b0;

    d = 8'h96;
    io_cmd_valid = 1'b1;
    io_cmd_data = d;
    @(posedge clk);
    @(negedge clk);
    io_cmd_valid = 1'b0;
    repeat (43) @(posedge clk);
    #2 chk("midshift_sdr", io_v_sdr, 1);
    reset = 1'b1;
    #1 chk("midshift_reset", outs, 15'h4000);
    @(negedge clk);
    reset = 1'b0;
    any_rsp = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (io_rsp_valid) any_rsp = 1'b1;
    end
    chk("no_rsp_after_reset", any_rsp, 0);
    scan(1'b1, 8'h5A, 2'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vjtag_scan_driver.md
Name: vjtag_scan_driver

Overview:
- Initiator side of the virtual-JTAG data-register protocol: generates `tck`, `tdi`, `ir_in`, `virtual_state_sdr` and `virtual_state_udr`, and samples `tdo`.
- Drives `vJTAG_interface` in simulation and board loopback without the Altera hub, and serves as the FPGA-internal master for the JTAG-to-core bridge self-test.
- Accepts one command (IR value plus data word) over a valid/ready handshake, performs a full shift/update scan, and returns the captured `tdo` word.

Parameters:
- DATA_W, 8: data-register length, i.e. shifted bits per scan.
- IR_W, 1: width of `io_ir_in`.
- CLK_DIV, 4: `clk` cycles per `tck` half-period; legal values 1 to 255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- io_cmd_valid  in  1  command present.
- io_cmd_ready  out  1  driver idle; the command is accepted when valid and ready are both high on a `clk` edge.
- io_cmd_ir  in  IR_W  IR value held for the whole scan.
- io_cmd_data  in  DATA_W  word to shift out, LSB first.
- io_rsp_valid  out  1  captured word available.
- io_rsp_ready  in  1  consumer takes the response.
- io_rsp_data  out  DATA_W  captured `tdo` bits; the first sampled bit lands at the LSB.
- io_tck  out  1  generated `tck`, registered, idles low.
- io_tdi  out  1  serial data to the target.
- io_tdo  in  1  serial data from the target.
- io_ir_in  out  IR_W  virtual IR.
- io_v_sdr  out  1  shift-DR state.
- io_udr  out  1  update-DR state.

Behaviour:
- Reset values: all outputs are 0 except `io_cmd_ready`, which is 1. State is IDLE and all counters are 0. Reset acts immediately at any point, including mid-scan; the driver never completes a partial scan.
- `tck` generator:
  - Runs only outside IDLE and DONE.
  - Half-period counter counts 0 to CLK_DIV-1; `io_tck` toggles at terminal count.
  - Each `tck` period is CLK_DIV low cycles followed by CLK_DIV high cycles.
- The FSM holds states IDLE, SETUP, SHIFT, UPDATE and DONE.
- IDLE:
  - `io_cmd_ready` = 1.
  - On acceptance, latch ir and data, drop ready, and go to SETUP.
  - `cmd_valid` without ready has no effect.
- SETUP, 1 `tck` period:
  - `io_ir_in` = latched ir from this state until DONE.
  - `sdr` = 0, `udr` = 0, `tdi` = data[0].
- SHIFT, DATA_W `tck` periods:
  - `io_v_sdr` = 1 for the whole state.
  - Bit i is on `io_tdi` for the full period, changing only at the falling edge.
  - On the `clk` edge where `io_tck` goes 0 to 1, sample `io_tdo` into the MSB of the capture register, which shifts right. After DATA_W samples, bit 0 holds the first sample.
  - Bit counter is `$clog2(DATA_W+1)` wide and counts 0 to DATA_W-1.
  - Leave SHIFT after the high phase of bit DATA_W-1 completes.
- UPDATE, 1 `tck` period:
  - `sdr` = 0, `io_udr` = 1, `tdi` = 0.
- DONE:
  - `io_tck` held low, `io_udr` = 0, `io_ir_in` = 0.
  - `io_rsp_valid` = 1 with `io_rsp_data` stable.
  - Hold until `io_rsp_ready`; on the handshake edge return to IDLE, where `rsp_valid` = 0 and `cmd_ready` = 1 on the next cycle.
  - No new command is accepted while DONE is pending.
- Latency: `io_rsp_valid` rises exactly (DATA_W+2)*2*CLK_DIV `clk` cycles after the acceptance edge. With defaults this is 80 cycles.
- Simultaneous events: a response handshake and a command in the same cycle do not overlap. The command is accepted in IDLE on the following cycle.
- `sdr` and `udr` are never high together. `io_tck` is glitch-free because it is a register output.

Decomposition:
- Shared package `vjtag_pkg`:
  - FSM state enum.
  - Default DATA_W / IR_W constants, shared with `vJTAG_interface` wrappers.
- One sub-module `vjtag_tck_gen`:
  - Half-period counter and `tck` register.
  - Outputs `rise_pulse`, `fall_pulse` and `period_done`, plus an `enable` input.
  - The FSM consumes only these pulses.

Test Plan:
- Reset: assert reset mid-cycle with no clock edge → all outputs 0 and `io_cmd_ready` = 1 immediately.
- Loopback `io_tdo` = `io_tdi`, command data 0xA5, ir 1 → `tdi` sequence is 1,0,1,0,0,1,0,1 across 8 `tck` rises with `sdr` = 1. `udr` is high for exactly 8 `clk` cycles. `rsp_valid` rises at cycle 80 with `rsp_data` = 0xA5 and `ir_in` = 1 during the scan.
- `io_tdo` tied 1, data 0x00 → `rsp_data` = 0xFF and `tdi` stays 0 throughout.
- Hold `rsp_ready` = 0 for 20 cycles after `rsp_valid` rises → `rsp_valid`/`rsp_data` stay stable and `cmd_ready` stays 0. A `cmd_valid` pulse in this window is ignored.
- Back-to-back: 0x3C then 0xC3 with `cmd_valid` held high and `rsp_ready` = 1 → two scans with a one-cycle IDLE gap, responses 0x3C and 0xC3 in order.
- Reset asserted during SHIFT bit 4 → outputs return to reset values and no `rsp_valid` appears. A following 0x5A command completes correctly.
